dump_ctrl: RTL

DUMP_CTRL -- requirements
Module: dump_ctrl

---
 rtl/la_pkg.sv | 20 ++
 rtl/wrap_cnt.sv | 34 +++
 rtl/dump_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser blocks (capture controller and
// dump controller).
//   LA_ENTRIES : default number of sample RAM entries
//   LA_LOG2    : default RAM address width (2**LA_LOG2 >= LA_ENTRIES)
//   dump_state_t : dump controller state encoding
package la_pkg;

  localparam int LA_ENTRIES = 384;
  localparam int LA_LOG2    = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    XMIT    = 3'd3,
    WAIT_TX = 3'd4,
    FINISH  = 3'd5
  } dump_state_t;

endpackage

// File: rtl/wrap_cnt.sv
// Address counter that wraps from ENTRIES-1 back to 0. ENTRIES need not be a
// power of two, so the wrap is an explicit compare rather than overflow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (q -> 0)
//   load, d    : load d into q (takes priority over inc)
//   inc        : advance q by one, wrapping at ENTRIES-1
//   q          : current address
module wrap_cnt
  import la_pkg::*;
#(
  parameter int ENTRIES = LA_ENTRIES,
  parameter int LOG2    = LA_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LOG2-1:0] d,
  input  logic            inc,
  output logic [LOG2-1:0] q
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= (q == LAST) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/dump_ctrl.sv
// Trace dump controller: on request, streams the captured sample RAM out over
// the UART, oldest sample first, one byte per transmitter handshake.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   dump_start    : request pulse from the command handler
//   capture_done  : capture RAM is full and holds a valid trace
//   waddr_end     : address of the oldest sample (capture write pointer)
//   rdata         : RAM read data, one cycle after raddr
//   tx_done       : UART byte-complete pulse
//   raddr         : RAM read address
//   tx_data       : byte handed to the UART (registered)
//   trmt          : one-cycle UART start pulse
//   dump_busy     : a dump is in progress
//   dump_nack     : one-cycle pulse, request refused (no trace captured)
//   clr_cap_done  : one-cycle pulse at the end of a dump
module dump_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = LA_ENTRIES,
  parameter int LOG2    = LA_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic            capture_done,
  input  logic [LOG2-1:0] waddr_end,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dump_busy,
  output logic            dump_nack,
  output logic            clr_cap_done
);

  // One bit wider than the address so the terminal value ENTRIES fits.
  localparam logic [LOG2:0] CNT_FULL = (LOG2 + 1)'(ENTRIES);

  dump_state_t     state_q;
  dump_state_t     state_d;
  logic [LOG2:0]   byte_cnt;
  logic            accept;
  logic            nack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // tx_done is only looked at in WAIT_TX; dump_start only in IDLE.
  // capture_done is only consulted at acceptance, so dropping it mid-dump
  // has no effect.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    nack_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          if (capture_done) begin
            accept  = 1'b1;
            state_d = READ;
          end else begin
            nack_d = 1'b1;
          end
        end
      end
      READ:    state_d = LATCH;
      LATCH:   state_d = XMIT;
      XMIT:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          state_d = (byte_cnt == CNT_FULL) ? FINISH : READ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle strobes decoded directly from the state register.
  assign trmt         = (state_q == XMIT);
  assign clr_cap_done = (state_q == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      tx_data   <= '0;
      dump_busy <= 1'b0;
      dump_nack <= 1'b0;
    end else begin
      dump_nack <= nack_d;
      if (accept) begin
        dump_busy <= 1'b1;
      end else if (state_q == FINISH) begin
        dump_busy <= 1'b0;
      end
      if (accept) begin
        byte_cnt <= '0;
      end else if (state_q == XMIT) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      // RAM output is valid in LATCH because raddr was held through READ.
      if (state_q == LATCH) begin
        tx_data <= rdata;
      end
    end
  end

  wrap_cnt #(
    .ENTRIES (ENTRIES),
    .LOG2    (LOG2)
  ) u_raddr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .d     (waddr_end),
    .inc   (state_q == XMIT),
    .q     (raddr)
  );

endmodule
